hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports d_rs, d_rt  input  5 each  source register numbers of the instruction in D.
REQ-006 SHALL have ports d_tuse_rs, d_tuse_rt  input  2 each  cycles until the operand is needed; 3 means never used.
REQ-007 SHALL have port d_is_md  input  1  the instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have ports e_wa, m_wa  input  5 each  destination registers in E and M; 0 means none.
REQ-009 SHALL have ports e_tnew, m_tnew  input  2 each  cycles until the E/M result is forwardable.
REQ-010 SHALL have ports e_md_start  input  1 and e_md_op  input  2  multiply/divide launch in E; op 0 mult, 1 multu, 2 div, 3 divu.
REQ-011 SHALL have port stall  output  1  freezes the PC (drives the PC delay input).
REQ-012 SHALL have port en_d  output  1  IF/ID register enable; always equal to ~stall.
REQ-013 SHALL have port flush_e  output  1  ID/EX clear, inserting a bubble; always equal to stall.
REQ-014 SHALL have ports md_busy  output  1 and stall_cnt  output  32  MDU busy flag and a saturating count of stall cycles.

Function
REQ-015 SHALL compute the data-hazard stall combinationally as:
  - (d_rs!=0 && d_rs==e_wa && d_tuse_rs<e_tnew), or
  - (d_rs!=0 && d_rs==m_wa && d_tuse_rs<m_tnew), or
  - the same two terms for d_rt.
REQ-016 SHALL treat a tuse of 3 as never less than any tnew.
REQ-017 SHALL assert the MDU stall when d_is_md && (md_busy || e_md_start).
REQ-018 SHALL assert stall as the OR of the data-hazard stall and the MDU stall, with no added latency.
REQ-019 SHALL implement a two-state FSM, IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-020 SHALL, in IDLE with e_md_start=1 at a clock edge:
  - load cnt with MULT_LAT for op 0/1, or DIV_LAT for op 2/3;
  - move to BUSY.
REQ-021 SHALL, in BUSY, decrement cnt each cycle and return to IDLE on the edge where cnt==1.
REQ-022 SHALL drive md_busy=1 exactly while in BUSY, giving MULT_LAT or DIV_LAT busy cycles starting the cycle after start.
REQ-023 SHALL ignore e_md_start while in BUSY: no reload and no state change.
REQ-024 SHALL increment stall_cnt on every clock edge with stall=1, and hold it at 32'hFFFF_FFFF once reached.
REQ-025 SHALL give the MDU stall and the data stall no priority over each other: a simultaneous cause produces a single stall cycle, counted once.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, cnt=0 and stall_cnt=0.
REQ-027 SHALL force stall=0, en_d=1 and flush_e=0 combinationally while reset=1.
REQ-028 SHALL have reset take precedence over e_md_start in the same cycle.
REQ-029 SHALL, on reset during BUSY, abort the operation with md_busy=0 on the next cycle.

Structure
REQ-030 SHALL place the tuse/tnew encodings, the TUSE_NEVER=3 constant, the MD op codes and the default latencies in shared package hazard_pkg.
REQ-031 SHALL implement the FSM and counter as sub-module md_busy_ctr (ports clk, reset, start, op, busy).
REQ-032 SHALL keep the hazard compare logic in hazard_ctrl.
REQ-033 SHALL make the total RTL 120-400 lines.

Verification
REQ-034 SHALL cover load-use: d_rs=5, d_tuse_rs=0, e_wa=5, e_tnew=2 -> stall=1, en_d=0, flush_e=1; with e_tnew=0 -> stall=0.
REQ-035 SHALL cover register zero: d_rs=0, e_wa=0, e_tnew=2, d_tuse_rs=0 -> stall=0.
REQ-036 SHALL cover mult: e_md_start=1, op=0 at cycle 0 -> md_busy=1 for cycles 1-5, 0 at cycle 6; d_is_md=1 in cycles 0-5 -> stall=1 there.
REQ-037 SHALL cover div: op=2 -> 10 busy cycles; a second e_md_start at cycle 3 -> busy still ends after cycle 10.
REQ-038 SHALL cover reset mid-BUSY: reset at cycle 4 of div -> md_busy=0 and stall_cnt=0 next cycle; stall=0 while reset=1.
REQ-039 SHALL cover the counter: 7 stalled cycles after reset -> stall_cnt=7; forced to 32'hFFFF_FFFF -> holds under further stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: tuse/tnew codes, multiply/divide ops, default MDU latencies.
// Pure declarations; no timing or backpressure of its own.
package hazard_pkg;

  // tuse: cycles until D needs the operand; TUSE_NEVER means the operand is never read.
  localparam logic [1:0] TUSE_0     = 2'd0;
  localparam logic [1:0] TUSE_1     = 2'd1;
  localparam logic [1:0] TUSE_2     = 2'd2;
  localparam logic [1:0] TUSE_NEVER = 2'd3;

  // tnew: cycles until the E/M result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;
  localparam logic [1:0] TNEW_3 = 2'd3;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  function automatic logic md_op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy tracker: busy for MULT_LAT or DIV_LAT cycles starting the cycle after start.
// Latency: busy rises one cycle after start; starts seen while busy are ignored.
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  logic [0:0] state;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= md_op_is_div(op) ? DIV_CNT : MULT_CNT;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: combinational data/MDU stall, PC freeze, D hold and E bubble.
// Latency: stall is same-cycle; stall_cnt counts stalled edges and saturates at all-ones.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic [1:0]  e_md_op,
  output logic        stall,
  output logic        en_d,
  output logic        flush_e,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic        data_stall;
  logic        md_stall;
  logic [31:0] stall_cnt_q;

  // A source waits when its producer is still in flight and the value is needed sooner than it appears.
  function automatic logic src_waits(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] wa,  input logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse != TUSE_NEVER) && (tuse < tnew);
  endfunction

  assign data_stall = src_waits(d_rs, d_tuse_rs, e_wa, e_tnew)
                    | src_waits(d_rs, d_tuse_rs, m_wa, m_tnew)
                    | src_waits(d_rt, d_tuse_rt, e_wa, e_tnew)
                    | src_waits(d_rt, d_tuse_rt, m_wa, m_tnew);

  assign md_stall = d_is_md & (md_busy | e_md_start);

  assign stall   = ~reset & (data_stall | md_stall);
  assign en_d    = ~stall;
  assign flush_e = stall;

  md_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_ctr (
    .clk   (clk),
    .reset (reset),
    .start (e_md_start),
    .op    (e_md_op),
    .busy  (md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
